// File: rtl/l2_mem_responder.sv
// L2-to-memory line responder: turns one 512-bit fill and/or writeback into 16 word accesses on a 32-bit RAM.
// Optional per-direction completion counters are built when L2_MEM_RESP_STATS_EN is defined.
module l2_mem_responder #(
    parameter int TNUM           = 18,
    parameter int INUM           = 8,
    parameter int RAM_WIDTH      = 32,
    parameter int LINE_WIDTH     = 512,
    parameter int RAM_ADDR_WIDTH = 22,
    parameter int RD_LAT         = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      read_L2_MEM,
    input  logic                      write_L2_MEM,
    input  logic [TNUM-1:0]           tag_L2_MEM,
    input  logic [INUM-1:0]           index_L2_MEM,
    input  logic [TNUM-1:0]           write_tag_L2_MEM,
    input  logic [LINE_WIDTH-1:0]     write_data_L2_MEM,
    output logic                      ready_MEM_L2,
    output logic [LINE_WIDTH-1:0]     read_data_MEM_L2,
    output logic                      ram_en,
    output logic                      ram_we,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [RAM_WIDTH-1:0]      ram_wdata,
    input  logic [RAM_WIDTH-1:0]      ram_rdata,
    output logic [31:0]               rd_count,
    output logic [31:0]               wr_count
);

    localparam int FULL_W = TNUM + INUM + 4;

    typedef enum logic [2:0] {IDLE, WB, FILL, DRAIN, DONE, HOLD} state_t;

    state_t                  state, state_nxt;
    logic [3:0]              beat;
    logic                    fill_pend;
    logic [TNUM-1:0]         tag_q;
    logic [TNUM-1:0]         wtag_q;
    logic [INUM-1:0]         idx_q;
    logic [LINE_WIDTH-1:0]   wdata_q;
    logic [FULL_W-1:0]       addr_full;
    logic                    issue_rd;
    logic                    last_cap;
    logic [RD_LAT-1:0]       vld;
    logic [3:0]              vbeat [RD_LAT];

    assign issue_rd = (state == FILL);
    assign last_cap = vld[RD_LAT-1] && (vbeat[RD_LAT-1] == 4'hF);
    assign ram_addr = addr_full[RAM_ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_wdata    = '0;
        addr_full    = '0;
        ready_MEM_L2 = 1'b0;
        case (state)
            IDLE: begin
                if (write_L2_MEM)     state_nxt = WB;
                else if (read_L2_MEM) state_nxt = FILL;
            end
            WB: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                addr_full = {wtag_q, idx_q, beat};
                ram_wdata = wdata_q[beat*RAM_WIDTH +: RAM_WIDTH];
                if (beat == 4'hF) state_nxt = fill_pend ? FILL : DONE;
            end
            FILL: begin
                ram_en    = 1'b1;
                addr_full = {tag_q, idx_q, beat};
                if (beat == 4'hF) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (last_cap) state_nxt = DONE;
            end
            DONE: begin
                ready_MEM_L2 = 1'b1;
                state_nxt    = HOLD;
            end
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Each read issue carries its beat number down a RD_LAT-deep pipe to pick its lane on return.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat             <= '0;
            fill_pend        <= 1'b0;
            tag_q            <= '0;
            wtag_q           <= '0;
            idx_q            <= '0;
            wdata_q          <= '0;
            vld              <= '0;
            read_data_MEM_L2 <= '0;
            for (int i = 0; i < RD_LAT; i++) vbeat[i] <= '0;
        end else begin
            vld[0]   <= issue_rd;
            vbeat[0] <= beat;
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i]   <= vld[i-1];
                vbeat[i] <= vbeat[i-1];
            end
            if (vld[RD_LAT-1])
                read_data_MEM_L2[vbeat[RD_LAT-1]*RAM_WIDTH +: RAM_WIDTH] <= ram_rdata;
            case (state)
                IDLE: begin
                    if (write_L2_MEM) begin
                        wtag_q    <= write_tag_L2_MEM;
                        idx_q     <= index_L2_MEM;
                        wdata_q   <= write_data_L2_MEM;
                        tag_q     <= tag_L2_MEM;
                        fill_pend <= read_L2_MEM;
                    end else if (read_L2_MEM) begin
                        tag_q     <= tag_L2_MEM;
                        idx_q     <= index_L2_MEM;
                        fill_pend <= 1'b1;
                    end
                end
                WB, FILL: beat <= beat + 4'd1;
                default: ;
            endcase
        end
    end

`ifdef L2_MEM_RESP_STATS_EN
    logic        wb_flag;
    logic [31:0] rd_q;
    logic [31:0] wr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_flag <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            if (state == IDLE) begin
                if (write_L2_MEM)     wb_flag <= 1'b1;
                else if (read_L2_MEM) wb_flag <= 1'b0;
            end
            if (state == DONE) begin
                if (fill_pend) rd_q <= rd_q + 32'd1;
                if (wb_flag)   wr_q <= wr_q + 32'd1;
            end
        end
    end

    assign rd_count = rd_q;
    assign wr_count = wr_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_l2_mem_responder.sv
// Bench for l2_mem_responder: RD_LAT=1 and RD_LAT=2 instances share request stimulus, each with its own RAM.
// Expected accesses, ready timing, line contents and counters come from a transaction-level model.
module tb_l2_mem_responder;

`ifdef L2_MEM_RESP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         rd_req, wr_req;
    logic [17:0]  tag, wtag;
    logic [7:0]   idx;
    logic [511:0] wdata;

    logic         rdy1, rdy2, en1, en2, we1, we2;
    logic [511:0] line1, line2;
    logic [21:0]  addr1, addr2;
    logic [31:0]  wd1, wd2, rc1, rc2, wc1, wc2;
    logic [31:0]  rdata1 = '0, rdata2 = '0, pipe2 = '0;

    l2_mem_responder #(.RD_LAT(1)) u1 (
        .clk(clk), .rst(rst), .read_L2_MEM(rd_req), .write_L2_MEM(wr_req),
        .tag_L2_MEM(tag), .index_L2_MEM(idx), .write_tag_L2_MEM(wtag), .write_data_L2_MEM(wdata),
        .ready_MEM_L2(rdy1), .read_data_MEM_L2(line1), .ram_en(en1), .ram_we(we1),
        .ram_addr(addr1), .ram_wdata(wd1), .ram_rdata(rdata1), .rd_count(rc1), .wr_count(wc1)
    );

    l2_mem_responder #(.RD_LAT(2)) u2 (
        .clk(clk), .rst(rst), .read_L2_MEM(rd_req), .write_L2_MEM(wr_req),
        .tag_L2_MEM(tag), .index_L2_MEM(idx), .write_tag_L2_MEM(wtag), .write_data_L2_MEM(wdata),
        .ready_MEM_L2(rdy2), .read_data_MEM_L2(line2), .ram_en(en2), .ram_we(we2),
        .ram_addr(addr2), .ram_wdata(wd2), .ram_rdata(rdata2), .rd_count(rc2), .wr_count(wc2)
    );

    // RAM word i holds i until written.
    logic [31:0] mem1 [int];
    logic [31:0] mem2 [int];
    logic [31:0] ref_mem [int];

    always @(posedge clk) if (en1 && we1) mem1[int'(addr1)] = wd1;
    always @(posedge clk) if (en2 && we2) mem2[int'(addr2)] = wd2;

    always @(posedge clk)
        rdata1 <= (en1 && !we1) ? (mem1.exists(int'(addr1)) ? mem1[int'(addr1)] : 32'(addr1)) : 32'h0;

    always @(posedge clk) begin
        pipe2  <= (en2 && !we2) ? (mem2.exists(int'(addr2)) ? mem2[int'(addr2)] : 32'(addr2)) : 32'h0;
        rdata2 <= pipe2;
    end

    int n_vec = 0, n_bad = 0;
    logic [511:0] exp_line = '0;
    int exp_rc = 0, exp_wc = 0;

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [21:0] addr_of(input logic [17:0] t, input logic [7:0] i, input int k);
        longint v;
        v = longint'(t) * 4096 + longint'(i) * 16 + longint'(k);
        return 22'(v % 4194304);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [21:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'(a);
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ctl1"}, {509'd0, en1, we1, rdy1}, 512'd0);
        chk({name, "_addr1"}, {wd1, 10'd0, addr1}, 512'd0);
        chk({name, "_line1"}, line1, 512'd0);
        chk({name, "_ctl2"}, {509'd0, en2, we2, rdy2}, 512'd0);
        chk({name, "_addr2"}, {wd2, 10'd0, addr2}, 512'd0);
        chk({name, "_line2"}, line2, 512'd0);
    endtask

    task automatic run_txn(input bit r, input bit w, input logic [17:0] tg, input logic [17:0] wt,
                           input logic [7:0] ix, input logic [511:0] wd, input int abort_k);
        logic [54:0]  expq[$], q1[$], q2[$];
        logic [21:0]  a;
        logic [511:0] l1, l2;
        int lat1, lat2, ncyc, r1c, r2c, r1at, r2at;
        r1c = 0; r2c = 0; r1at = -1; r2at = -1; l1 = '0; l2 = '0;

        if (w)
            for (int k = 0; k < 16; k++)
                if (abort_k < 0 || k <= abort_k) begin
                    a = addr_of(wt, ix, k);
                    expq.push_back({1'b1, a, wd[32*k +: 32]});
                    ref_mem[int'(a)] = wd[32*k +: 32];
                end
        if (r && abort_k < 0)
            for (int k = 0; k < 16; k++) begin
                a = addr_of(tg, ix, k);
                expq.push_back({1'b0, a, 32'h0});
                exp_line[32*k +: 32] = ref_rd(a);
            end
        lat1 = (r && w) ? 34 : (w ? 17 : 18);
        lat2 = r ? lat1 + 1 : lat1;
        if (abort_k >= 0) begin
            exp_line = '0; exp_rc = 0; exp_wc = 0;
        end else begin
            exp_rc += int'(r); exp_wc += int'(w);
        end

        @(negedge clk);
        rd_req = r; wr_req = w; tag = tg; wtag = wt; idx = ix; wdata = wd;
        @(posedge clk);
        #1;
        tag = 18'($urandom); wtag = 18'($urandom); idx = 8'($urandom); wdata = rand512();

        ncyc = (abort_k >= 0) ? abort_k + 1 : lat2 + 4;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (en1) q1.push_back({we1, addr1, we1 ? wd1 : 32'h0});
            if (en2) q2.push_back({we2, addr2, we2 ? wd2 : 32'h0});
            if (rdy1) begin r1c++; r1at = c; l1 = line1; end
            if (rdy2) begin r2c++; r2at = c; l2 = line2; end
            if (rdy1 || rdy2) begin rd_req = 1'b0; wr_req = 1'b0; end
        end

        if (abort_k >= 0) begin
            rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
            @(negedge clk);
            chk_reset_outputs("abort");
            rst = 1'b0;
            chk("abort_ready1", 512'(r1c), 512'd0);
            chk("abort_ready2", 512'(r2c), 512'd0);
        end else begin
            chk("ready_pulses1", 512'(r1c), 512'd1);
            chk("ready_pulses2", 512'(r2c), 512'd1);
            chk("ready_cycle1", 512'(r1at), 512'(lat1));
            chk("ready_cycle2", 512'(r2at), 512'(lat2));
            chk("line1", l1, exp_line);
            chk("line2", l2, exp_line);
        end

        chk("acc_count1", 512'(q1.size()), 512'(expq.size()));
        chk("acc_count2", 512'(q2.size()), 512'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            chk("access1", (i < q1.size()) ? 512'(q1[i]) : {512{1'bx}}, 512'(expq[i]));
            chk("access2", (i < q2.size()) ? 512'(q2[i]) : {512{1'bx}}, 512'(expq[i]));
        end
        chk("rd_count1", 512'(rc1), STATS ? 512'(exp_rc) : 512'd0);
        chk("wr_count1", 512'(wc1), STATS ? 512'(exp_wc) : 512'd0);
        chk("rd_count2", 512'(rc2), STATS ? 512'(exp_rc) : 512'd0);
        chk("wr_count2", 512'(wc2), STATS ? 512'(exp_wc) : 512'd0);
    endtask

    logic [511:0] seq_data;
    bit           rr, ww;

    initial begin
        rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
        tag = '0; wtag = '0; idx = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        chk("reset_cnt1", {448'd0, rc1, wc1}, 512'd0);
        chk("reset_cnt2", {448'd0, rc2, wc2}, 512'd0);
        rst = 1'b0;

        run_txn(1'b1, 1'b0, 18'h00001, 18'h0, 8'h02, '0, -1);
        for (int k = 0; k < 16; k++) seq_data[32*k +: 32] = 32'hA000_0000 + k;
        run_txn(1'b0, 1'b1, 18'h0, 18'h00003, 8'h00, seq_data, -1);
        run_txn(1'b1, 1'b1, 18'h00001, 18'h00003, 8'h05, rand512(), -1);
        run_txn(1'b0, 1'b1, 18'h0, 18'h00003, 8'h09, rand512(), 7);
        run_txn(1'b1, 1'b0, 18'h00003, 18'h0, 8'h09, '0, -1);

        for (int n = 0; n < 20; n++) begin
            rr = 1'($urandom);
            ww = 1'($urandom);
            if (!rr && !ww) rr = 1'b1;
            run_txn(rr, ww, 18'($urandom_range(0, 15)), 18'($urandom_range(0, 15)),
                    8'($urandom), rand512(), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
